// File: rtl/deser_rx.sv
// Serial frame receiver: start bit, WIDTH data bits LSB-first, stop bit.
// Two-flop input synchronizer feeding a four-state framing FSM.
module deser_rx #(
    parameter int WIDTH = 8
) (
    input  logic             CK,
    input  logic             RST_N,
    input  logic             D,
    output logic [WIDTH-1:0] Q,
    output logic             VALID,
    output logic             FERR,
    output logic             BUSY
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_STOP,
        S_BRK
    } state_t;

    state_t         state;
    state_t         nstate;
    logic           s1;
    logic           s2;
    logic [CW-1:0]  cnt;
    logic [WIDTH-1:0] sr;
    logic           clr;
    logic           shift;
    logic           load;
    logic           ferr_set;

    // Synchronize the serial line; idle level is 1.
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= D;
            s2 <= s1;
        end
    end

    // FSM state register.
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= nstate;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        nstate   = state;
        clr      = 1'b0;
        shift    = 1'b0;
        load     = 1'b0;
        ferr_set = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!s2) begin
                    nstate = S_DATA;
                    clr    = 1'b1;
                end
            end
            S_DATA: begin
                shift = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    nstate = S_STOP;
                end
            end
            S_STOP: begin
                if (s2) begin
                    load   = 1'b1;
                    nstate = S_IDLE;
                end else begin
                    ferr_set = 1'b1;
                    nstate   = S_BRK;
                end
            end
            S_BRK: begin
                if (s2) begin
                    nstate = S_IDLE;
                end
            end
            default: begin
                nstate = S_IDLE;
            end
        endcase
    end

    // Bit counter and LSB-first shift register.
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
            sr  <= '0;
        end else begin
            if (clr) begin
                cnt <= '0;
            end else if (shift) begin
                cnt <= cnt + CW'(1);
            end
            if (shift) begin
                sr <= {s2, sr[WIDTH-1:1]};
            end
        end
    end

    // Output word and one-cycle status pulses.
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            Q     <= '0;
            VALID <= 1'b0;
            FERR  <= 1'b0;
        end else begin
            if (load) begin
                Q <= sr;
            end
            VALID <= load;
            FERR  <= ferr_set;
        end
    end

    assign BUSY = (state != S_IDLE);

endmodule

// File: tb/tb_deser_rx.sv
// Directed self-checking bench for deser_rx (WIDTH=8).
// Edge k of each loop is E0+k where E0 captures the start bit.
module tb_deser_rx;

    logic       CK;
    logic       RST_N;
    logic       D;
    logic [7:0] Q;
    logic       VALID;
    logic       FERR;
    logic       BUSY;

    int nchk = 0;
    int nerr = 0;
    int vcnt = 0;
    int fcnt = 0;
    int bcnt = 0;

    deser_rx #(.WIDTH(8)) dut (
        .CK   (CK),
        .RST_N(RST_N),
        .D    (D),
        .Q    (Q),
        .VALID(VALID),
        .FERR (FERR),
        .BUSY (BUSY)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // Pulse counters sampled on the falling edge.
    always @(negedge CK) begin
        if (VALID) vcnt++;
        if (FERR)  fcnt++;
        if (BUSY)  bcnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic b);
        D = b;
        @(posedge CK);
        #1;
    endtask

    initial begin
        logic [9:0]  w;
        logic [19:0] w2;
        int v0, f0, b0;
        logic b;

        D     = 1'b1;
        RST_N = 1'b0;
        #1;
        chk("reset_async", {24'h0, Q, VALID, FERR, BUSY}, 32'h0);

        for (int i = 0; i < 6; i++) begin
            step(i[0]);
            chk("reset_hold", {21'h0, Q, VALID, FERR, BUSY}, 32'h0);
        end

        D = 1'b1;
        #3 RST_N = 1'b1;
        #1;
        chk("release_quiet", {21'h0, Q, VALID, FERR, BUSY}, 32'h0);

        // Idle line after reset.
        v0 = vcnt; f0 = fcnt; b0 = bcnt;
        for (int i = 0; i < 50; i++) step(1'b1);
        chk("idle_valid", vcnt - v0, 0);
        chk("idle_ferr", fcnt - f0, 0);
        chk("idle_busy", bcnt - b0, 0);
        chk("idle_q", Q, 8'h00);

        // Single 0xA5 frame.
        w = {1'b1, 8'hA5, 1'b0};
        v0 = vcnt; f0 = fcnt;
        for (int k = 0; k < 14; k++) begin
            b = (k < 10) ? w[k] : 1'b1;
            step(b);
            chk($sformatf("a5_valid_k%0d", k), VALID, (k == 11));
            chk($sformatf("a5_busy_k%0d", k), BUSY,
                (k >= 2 && k <= 10));
            if (k == 11) chk("a5_q", Q, 8'hA5);
        end
        chk("a5_vcount", vcnt - v0, 1);
        chk("a5_fcount", fcnt - f0, 0);

        // Back-to-back 0x3C then 0xC3.
        w2 = {1'b1, 8'hC3, 1'b0, 1'b1, 8'h3C, 1'b0};
        v0 = vcnt; f0 = fcnt;
        for (int k = 0; k < 24; k++) begin
            b = (k < 20) ? w2[k] : 1'b1;
            step(b);
            chk($sformatf("b2b_valid_k%0d", k), VALID,
                (k == 11 || k == 21));
            chk($sformatf("b2b_busy_k%0d", k), BUSY,
                (k >= 2 && k <= 20 && k != 11));
            if (k == 11) chk("b2b_q1", Q, 8'h3C);
            if (k == 15) chk("b2b_qhold", Q, 8'h3C);
            if (k == 21) chk("b2b_q2", Q, 8'hC3);
        end
        chk("b2b_vcount", vcnt - v0, 2);
        chk("b2b_fcount", fcnt - f0, 0);

        // Framing error: 0x5A with stop=0, line low 5 more cycles.
        w = {1'b0, 8'h5A, 1'b0};
        v0 = vcnt; f0 = fcnt;
        for (int k = 0; k < 30; k++) begin
            b = (k < 10) ? w[k] : ((k < 15) ? 1'b0 : 1'b1);
            step(b);
            chk($sformatf("fe_ferr_k%0d", k), FERR, (k == 11));
            chk($sformatf("fe_busy_k%0d", k), BUSY,
                (k >= 2 && k <= 16));
            chk($sformatf("fe_q_k%0d", k), Q, 8'hC3);
        end
        chk("fe_vcount", vcnt - v0, 0);
        chk("fe_fcount", fcnt - f0, 1);

        // Reset after the 4th data bit, then a clean 0x81 frame.
        w = {1'b1, 8'h0F, 1'b0};
        v0 = vcnt; f0 = fcnt;
        for (int k = 0; k < 5; k++) step(w[k]);
        chk("mr_busy_before", BUSY, 1'b1);
        D = 1'b1;
        RST_N = 1'b0;
        #1;
        chk("mr_async", {21'h0, Q, VALID, FERR, BUSY}, 32'h0);
        step(1'b1);
        step(1'b1);
        #3 RST_N = 1'b1;
        #1;
        chk("mr_release", {21'h0, Q, VALID, FERR, BUSY}, 32'h0);
        step(1'b1);
        chk("mr_abort_v", vcnt - v0, 0);
        chk("mr_abort_f", fcnt - f0, 0);

        w = {1'b1, 8'h81, 1'b0};
        v0 = vcnt; f0 = fcnt;
        for (int k = 0; k < 14; k++) begin
            b = (k < 10) ? w[k] : 1'b1;
            step(b);
            chk($sformatf("x81_valid_k%0d", k), VALID, (k == 11));
            if (k == 11) chk("x81_q", Q, 8'h81);
        end
        chk("x81_vcount", vcnt - v0, 1);
        chk("x81_fcount", fcnt - f0, 0);
        chk("x81_qhold", Q, 8'h81);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
